// File: rtl/send_merge_arbiter.sv
// send_merge_arbiter: weighted, registered merge of RX-queue control packets
// and TX-pipe data packets onto the single send destination.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   tx_pipe_merger_tx_*           TX pipe packet (val/rdy handshake)
//   rx_pipe_merger_tx_empty       RX send queue empty flag
//   rx_pipe_merger_tx_deq_resp_data / _deq_req_val  RX queue head / pop
//   send_dst_tx_*                 registered output packet (val/rdy)
//   dst_send_tx_rdy               destination ready

`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package send_merge_pkg;

    localparam int FLOWID_W = 8;
    localparam int IP_W     = `IP_ADDR_W;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
    } tcp_pkt_hdr;

    typedef struct packed {
        logic [31:0] payload_addr;
        logic [15:0] payload_len;
    } payload_buf_struct;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        logic [IP_W-1:0]     src_ip;
        logic [IP_W-1:0]     dst_ip;
        tcp_pkt_hdr          tcp_hdr;
    } rx_send_queue_struct;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        logic [IP_W-1:0]     src_ip;
        logic [IP_W-1:0]     dst_ip;
        tcp_pkt_hdr          tcp_hdr;
        payload_buf_struct   payload;
    } merge_pkt_t;

endpackage

module send_merge_arbiter
    import send_merge_pkg::*;
#(
    parameter int RX_BURST = 4,
    parameter int TX_BURST = 2
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                tx_pipe_merger_tx_val,
    input  logic [FLOWID_W-1:0] tx_pipe_merger_tx_flowid,
    input  logic [IP_W-1:0]     tx_pipe_merger_tx_src_ip,
    input  logic [IP_W-1:0]     tx_pipe_merger_tx_dst_ip,
    input  tcp_pkt_hdr          tx_pipe_merger_tx_tcp_hdr,
    input  payload_buf_struct   tx_pipe_merger_tx_payload,
    output logic                merger_tx_pipe_tx_rdy,

    input  logic                rx_pipe_merger_tx_empty,
    input  rx_send_queue_struct rx_pipe_merger_tx_deq_resp_data,
    output logic                rx_pipe_merger_tx_deq_req_val,

    output logic                send_dst_tx_val,
    output logic [FLOWID_W-1:0] send_dst_tx_flowid,
    output logic [IP_W-1:0]     send_dst_tx_src_ip,
    output logic [IP_W-1:0]     send_dst_tx_dst_ip,
    output tcp_pkt_hdr          send_dst_tx_tcp_hdr,
    output payload_buf_struct   send_dst_tx_payload,
    input  logic                dst_send_tx_rdy
);

    localparam int MAX_BURST =
        (RX_BURST > TX_BURST) ? RX_BURST : TX_BURST;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0] RX_LIM  = CNT_W'(RX_BURST);
    localparam logic [CNT_W-1:0] TX_LIM  = CNT_W'(TX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        OWN_RX = 1'b0,
        OWN_TX = 1'b1
    } owner_e;

    logic             out_val_q, out_val_d;
    merge_pkt_t       out_pkt_q, out_pkt_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

    logic       load_en;
    logic       req_rx;
    logic       req_tx;
    logic       tx_pref;
    logic       grant_rx;
    logic       grant_tx;
    logic       same_src;
    merge_pkt_t tx_pkt;
    merge_pkt_t rx_pkt;

    // Arbitration point; the output register frees up when drained.
    always_comb begin
        load_en = ~out_val_q | dst_send_tx_rdy;
        req_rx  = ~rx_pipe_merger_tx_empty;
        req_tx  = tx_pipe_merger_tx_val;

        // TX keeps its slot until its burst is spent; RX yields only
        // once its own burst is spent.
        if (owner_q == OWN_TX) begin
            tx_pref = (run_cnt_q < TX_LIM);
        end else begin
            tx_pref = (run_cnt_q >= RX_LIM);
        end

        // rdy must not depend on tx_val, so it is computed first.
        merger_tx_pipe_tx_rdy = load_en & (~req_rx | tx_pref);
        grant_tx = req_tx & merger_tx_pipe_tx_rdy;
        grant_rx = load_en & req_rx & ~grant_tx;
        rx_pipe_merger_tx_deq_req_val = grant_rx;
    end

    always_comb begin
        tx_pkt.flowid  = tx_pipe_merger_tx_flowid;
        tx_pkt.src_ip  = tx_pipe_merger_tx_src_ip;
        tx_pkt.dst_ip  = tx_pipe_merger_tx_dst_ip;
        tx_pkt.tcp_hdr = tx_pipe_merger_tx_tcp_hdr;
        tx_pkt.payload = tx_pipe_merger_tx_payload;

        // Control packets carry no payload.
        rx_pkt.flowid  = rx_pipe_merger_tx_deq_resp_data.flowid;
        rx_pkt.src_ip  = rx_pipe_merger_tx_deq_resp_data.src_ip;
        rx_pkt.dst_ip  = rx_pipe_merger_tx_deq_resp_data.dst_ip;
        rx_pkt.tcp_hdr = rx_pipe_merger_tx_deq_resp_data.tcp_hdr;
        rx_pkt.payload = '0;
    end

    always_comb begin
        out_val_d = out_val_q;
        out_pkt_d = out_pkt_q;
        owner_d   = owner_q;
        run_cnt_d = run_cnt_q;
        same_src  = 1'b0;

        unique case (1'b1)
            grant_tx: out_pkt_d = tx_pkt;
            grant_rx: out_pkt_d = rx_pkt;
            default:  out_pkt_d = out_pkt_q;
        endcase

        // A drain with a new grant reloads without a bubble.
        if (grant_rx | grant_tx) begin
            out_val_d = 1'b1;
        end else if (load_en) begin
            out_val_d = 1'b0;
        end

        if (grant_rx | grant_tx) begin
            same_src = (grant_tx & (owner_q == OWN_TX)) |
                       (grant_rx & (owner_q == OWN_RX));
            if (same_src) begin
                if (run_cnt_q != CNT_MAX) begin
                    run_cnt_d = run_cnt_q + CNT_ONE;
                end
            end else begin
                owner_d   = grant_tx ? OWN_TX : OWN_RX;
                run_cnt_d = CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_q <= 1'b0;
            out_pkt_q <= '0;
            owner_q   <= OWN_RX;
            run_cnt_q <= '0;
        end else begin
            out_val_q <= out_val_d;
            out_pkt_q <= out_pkt_d;
            owner_q   <= owner_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign send_dst_tx_val     = out_val_q;
    assign send_dst_tx_flowid  = out_pkt_q.flowid;
    assign send_dst_tx_src_ip  = out_pkt_q.src_ip;
    assign send_dst_tx_dst_ip  = out_pkt_q.dst_ip;
    assign send_dst_tx_tcp_hdr = out_pkt_q.tcp_hdr;
    assign send_dst_tx_payload = out_pkt_q.payload;

endmodule
